// File: rtl/dispatch_pkg.sv
// Shared definitions for the issue scheduler: CDB owner codes, the
// reservation-slot record and default widths.
package dispatch_pkg;

  localparam int TAG_W_DEFAULT   = 5;
  localparam int MUL_LAT_DEFAULT = 4;

  // Which execution unit owns the CDB in a given cycle.
  typedef enum logic [1:0] {
    CDB_SRC_NONE = 2'b00,
    CDB_SRC_INT  = 2'b01,
    CDB_SRC_LDST = 2'b10,
    CDB_SRC_MUL  = 2'b11
  } cdb_src_e;

  // One CDB reservation: owner and the ROB tag it will drive.
  typedef struct packed {
    cdb_src_e                 src;
    logic [TAG_W_DEFAULT-1:0] tag;
  } cdb_slot_t;

endpackage

// File: rtl/cdb_slot_shreg.sv
// CDB reservation shift register. Slot k names the bus owner k cycles from
// now. Single-cycle units load at slot 0, the multiplier loads at the far
// end, and everything else moves one slot closer each cycle.
module cdb_slot_shreg
  import dispatch_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT,
  parameter int TAG_W   = TAG_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             head_load,
  input  logic [1:0]       head_src,
  input  logic [TAG_W-1:0] head_tag,
  input  logic             tail_load,
  input  logic [TAG_W-1:0] tail_tag,
  output logic             slot1_free,
  output logic [1:0]       cdb_src,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [3:0]       busy
);

  cdb_src_e         src_q [MUL_LAT];
  logic [TAG_W-1:0] tag_q [MUL_LAT];

  // Advance reservations one slot per cycle; load new owners at both ends.
  // NOTE: non-blocking assignments let every slot read its neighbour's old
  // value, so the shift happens in parallel regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the slot array is reset (unlike a data RAM) because a stale
      // owner would be driven onto the CDB and would block int/LD-ST grants.
      for (int k = 0; k < MUL_LAT; k++) begin
        src_q[k] <= CDB_SRC_NONE;
        tag_q[k] <= '0;
      end
    end else begin
      for (int k = 1; k < MUL_LAT - 1; k++) begin
        src_q[k] <= src_q[k+1];
        tag_q[k] <= tag_q[k+1];
      end
      // A head load only happens when slot 1 is empty, so nothing is lost.
      if (head_load) begin
        src_q[0] <= cdb_src_e'(head_src);
        tag_q[0] <= head_tag;
      end else begin
        src_q[0] <= src_q[1];
        tag_q[0] <= tag_q[1];
      end
      src_q[MUL_LAT-1] <= tail_load ? CDB_SRC_MUL : CDB_SRC_NONE;
      tag_q[MUL_LAT-1] <= tail_load ? tail_tag : '0;
    end
  end

  assign slot1_free = (src_q[1] == CDB_SRC_NONE);
  assign cdb_src    = src_q[0];
  assign cdb_tag    = tag_q[0];

  // Count occupied slots, including the current bus owner in slot 0.
  always_comb begin
    busy = '0;
    for (int k = 0; k < MUL_LAT; k++) begin
      busy = busy + {3'b000, (src_q[k] != CDB_SRC_NONE)};
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Issue scheduler: grants one integer-or-LD/ST instruction and optionally
// one multiply per cycle, booking CDB cycles so no two results collide.
module issue_scheduler
  import dispatch_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT,
  parameter int TAG_W   = TAG_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issueque_int_ready,
  input  logic [TAG_W-1:0] issueque_int_tag,
  input  logic             issueque_ld_st_ready,
  input  logic [TAG_W-1:0] issueque_ld_st_tag,
  input  logic             issueque_mul_ready,
  input  logic [TAG_W-1:0] issueque_mul_tag,
  input  logic             Cdb_flush,
  output logic             issue_int,
  output logic             issue_ld_st,
  output logic             issue_mul,
  output logic [1:0]       cdb_sel,
  output logic [TAG_W-1:0] cdb_expect_tag,
  output logic [3:0]       cdb_slots_busy
);

  logic             slot1_free;
  logic             lru;        // 1: LD/ST granted most recently, int wins next tie
  logic             head_load;
  cdb_src_e         head_src;
  logic [TAG_W-1:0] head_tag;

  // Arbitrate int vs LD/ST by LRU when next cycle's CDB slot is free;
  // the multiplier's slot at distance MUL_LAT is always free.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    issue_int   = 1'b0;
    issue_ld_st = 1'b0;
    issue_mul   = 1'b0;
    if (!reset && !Cdb_flush) begin
      issue_mul = issueque_mul_ready;
      if (slot1_free) begin
        if (issueque_int_ready && issueque_ld_st_ready) begin
          issue_int   = lru;
          issue_ld_st = !lru;
        end else begin
          issue_int   = issueque_int_ready;
          issue_ld_st = issueque_ld_st_ready;
        end
      end
    end
  end

  assign head_load = issue_int | issue_ld_st;
  assign head_src  = issue_int ? CDB_SRC_INT : CDB_SRC_LDST;
  assign head_tag  = issue_int ? issueque_int_tag : issueque_ld_st_tag;

  // Remember which single-cycle queue was served last.
  always_ff @(posedge clock) begin
    if (reset) begin
      lru <= 1'b1;
    end else if (issue_int) begin
      lru <= 1'b0;
    end else if (issue_ld_st) begin
      lru <= 1'b1;
    end
  end

  cdb_slot_shreg #(
    .MUL_LAT (MUL_LAT),
    .TAG_W   (TAG_W)
  ) u_slots (
    .clock      (clock),
    .reset      (reset),
    .head_load  (head_load),
    .head_src   (head_src),
    .head_tag   (head_tag),
    .tail_load  (issue_mul),
    .tail_tag   (issueque_mul_tag),
    .slot1_free (slot1_free),
    .cdb_src    (cdb_sel),
    .cdb_tag    (cdb_expect_tag),
    .busy       (cdb_slots_busy)
  );

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: a per-cycle CDB booking calendar model checked
// at every falling edge, plus directed scenarios with literal expectations.
module tb_issue_scheduler;
  import dispatch_pkg::*;

  localparam int MUL_LAT = 4;
  localparam int TAG_W   = 5;
  localparam int DEPTH   = 512;

  logic             clock = 1'b0;
  logic             reset;
  logic             issueque_int_ready;
  logic [TAG_W-1:0] issueque_int_tag;
  logic             issueque_ld_st_ready;
  logic [TAG_W-1:0] issueque_ld_st_tag;
  logic             issueque_mul_ready;
  logic [TAG_W-1:0] issueque_mul_tag;
  logic             Cdb_flush;
  logic             issue_int;
  logic             issue_ld_st;
  logic             issue_mul;
  logic [1:0]       cdb_sel;
  logic [TAG_W-1:0] cdb_expect_tag;
  logic [3:0]       cdb_slots_busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  issue_scheduler #(
    .MUL_LAT (MUL_LAT),
    .TAG_W   (TAG_W)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .issueque_int_ready   (issueque_int_ready),
    .issueque_int_tag     (issueque_int_tag),
    .issueque_ld_st_ready (issueque_ld_st_ready),
    .issueque_ld_st_tag   (issueque_ld_st_tag),
    .issueque_mul_ready   (issueque_mul_ready),
    .issueque_mul_tag     (issueque_mul_tag),
    .Cdb_flush            (Cdb_flush),
    .issue_int            (issue_int),
    .issue_ld_st          (issue_ld_st),
    .issue_mul            (issue_mul),
    .cdb_sel              (cdb_sel),
    .cdb_expect_tag       (cdb_expect_tag),
    .cdb_slots_busy       (cdb_slots_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a calendar of who owns the CDB in each absolute cycle.
  cdb_slot_t sched [DEPTH];
  logic      lru_m;
  logic      model_valid;

  initial begin
    logic exp_int, exp_ls, exp_mul;
    int   t, n;
    for (int i = 0; i < DEPTH; i++) sched[i] = '{CDB_SRC_NONE, '0};
    lru_m       = 1'b1;
    model_valid = 1'b0;
    t           = 0;
    forever begin
      @(negedge clock);
      if (t + MUL_LAT + 2 >= DEPTH) begin
        $display("FAIL model_calendar_overflow cycle=%0d limit=%0d", t, DEPTH);
        $fatal(1);
      end
      exp_int = 1'b0;
      exp_ls  = 1'b0;
      exp_mul = 1'b0;
      if (!reset && !Cdb_flush) begin
        exp_mul = issueque_mul_ready;
        if (sched[t+1].src == CDB_SRC_NONE) begin
          if (issueque_int_ready && issueque_ld_st_ready) begin
            exp_int = lru_m;
            exp_ls  = !lru_m;
          end else begin
            exp_int = issueque_int_ready;
            exp_ls  = issueque_ld_st_ready;
          end
        end
      end
      check("m_issue_int", issue_int, exp_int);
      check("m_issue_ld_st", issue_ld_st, exp_ls);
      check("m_issue_mul", issue_mul, exp_mul);
      check("m_single_grant", issue_int & issue_ld_st, 0);
      check("m_grant_needs_ready",
            (issue_int & !issueque_int_ready) | (issue_ld_st & !issueque_ld_st_ready) |
            (issue_mul & !issueque_mul_ready), 0);
      if (model_valid) begin
        n = 0;
        for (int k = 0; k < MUL_LAT; k++) if (sched[t+k].src != CDB_SRC_NONE) n++;
        check("m_cdb_sel", cdb_sel, sched[t].src);
        check("m_cdb_tag", cdb_expect_tag, sched[t].tag);
        check("m_busy", cdb_slots_busy, n);
      end
      if (reset) begin
        for (int k = t + 1; k <= t + MUL_LAT + 1; k++) sched[k] = '{CDB_SRC_NONE, '0};
        lru_m       = 1'b1;
        model_valid = 1'b1;
      end else begin
        if (exp_int) begin
          sched[t+1] = '{CDB_SRC_INT, issueque_int_tag};
          lru_m      = 1'b0;
        end
        if (exp_ls) begin
          sched[t+1] = '{CDB_SRC_LDST, issueque_ld_st_tag};
          lru_m      = 1'b1;
        end
        if (exp_mul) sched[t+MUL_LAT] = '{CDB_SRC_MUL, issueque_mul_tag};
      end
      t++;
    end
  end

  task automatic drive(input logic ir, input logic [TAG_W-1:0] it,
                       input logic lr, input logic [TAG_W-1:0] lt,
                       input logic mr, input logic [TAG_W-1:0] mt,
                       input logic fl);
    issueque_int_ready   = ir;
    issueque_int_tag     = it;
    issueque_ld_st_ready = lr;
    issueque_ld_st_tag   = lt;
    issueque_mul_ready   = mr;
    issueque_mul_tag     = mt;
    Cdb_flush            = fl;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout time=%0t", $time);
    $fatal(1);
  end

  // Directed scenarios; inputs change 1 ns after each rising edge.
  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #2;
    check("rst_cdb_sel", cdb_sel, 0);
    check("rst_cdb_tag", cdb_expect_tag, 0);
    check("rst_busy", cdb_slots_busy, 0);
    next();

    // Int and LD/ST contend every cycle: LRU alternates, int first.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, '0, 1'b0);
      #2;
      check("alt_issue_int", issue_int, (i % 2 == 0));
      check("alt_issue_ld_st", issue_ld_st, (i % 2 == 1));
      if (i > 0) check("alt_cdb_sel", cdb_sel, (i % 2 == 1) ? 1 : 2);
      next();
    end
    idle();
    #2;
    check("alt_cdb_sel_last", cdb_sel, 2);
    check("alt_cdb_tag_last", cdb_expect_tag, 2);
    next();

    // Lone integer instruction: one-cycle issue-to-CDB latency.
    drive(1'b1, 5'd3, 1'b0, '0, 1'b0, '0, 1'b0);
    #2;
    check("int_grant", issue_int, 1);
    next();
    idle();
    #2;
    check("int_cdb_sel", cdb_sel, 1);
    check("int_cdb_tag", cdb_expect_tag, 3);
    next();
    #2;
    check("int_cdb_sel_clear", cdb_sel, 0);
    next();

    // Multiply books the CDB MUL_LAT cycles out and blocks int the cycle before.
    for (int c = 0; c <= 4; c++) begin
      drive(1'b1, 5'd4, 1'b0, '0, (c == 0), 5'd7, 1'b0);
      #2;
      if (c == 0) check("mul_grant", issue_mul, 1);
      if (c == 3) check("int_blocked_by_mul", issue_int, 0);
      if (c == 4) begin
        check("mul_cdb_sel", cdb_sel, 3);
        check("mul_cdb_tag", cdb_expect_tag, 7);
        check("int_regrant", issue_int, 1);
      end
      next();
    end
    idle();
    repeat (MUL_LAT + 1) next();

    // Back-to-back multiplies fill the whole reservation register.
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive(1'b0, '0, 1'b0, '0, 1'b1, TAG_W'(8 + c), 1'b0);
      else idle();
      #2;
      if (c < 4) begin
        check("burst_mul_grant", issue_mul, 1);
      end else begin
        check("burst_cdb_sel", cdb_sel, 3);
        check("burst_cdb_tag", cdb_expect_tag, 8 + c - 4);
        check("burst_busy", cdb_slots_busy, 8 - c);
      end
      next();
    end
    idle();
    repeat (2) next();

    // Flush blocks new grants only; earlier bookings still reach the CDB.
    for (int c = 0; c <= 4; c++) begin
      if (c <= 2) drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd9, (c == 2));
      else idle();
      #2;
      if (c == 2) begin
        check("flush_no_int", issue_int, 0);
        check("flush_no_ld_st", issue_ld_st, 0);
        check("flush_no_mul", issue_mul, 0);
        check("flush_cdb_sel", cdb_sel, 1);
        check("flush_cdb_tag", cdb_expect_tag, 5);
      end
      if (c == 4) begin
        check("flush_mul_sel", cdb_sel, 3);
        check("flush_mul_tag", cdb_expect_tag, 9);
      end
      next();
    end
    idle();
    repeat (MUL_LAT + 1) next();

    // Reset with three slots busy clears the calendar and restores int priority.
    drive(1'b1, 5'd10, 1'b0, '0, 1'b1, 5'd12, 1'b0);
    next();
    drive(1'b0, '0, 1'b0, '0, 1'b1, 5'd13, 1'b0);
    next();
    drive(1'b0, '0, 1'b0, '0, 1'b1, 5'd14, 1'b0);
    next();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd15, 1'b0);
    reset = 1'b1;
    #2;
    check("pre_rst_busy", cdb_slots_busy, 3);
    check("rst_no_int", issue_int, 0);
    check("rst_no_ld_st", issue_ld_st, 0);
    check("rst_no_mul", issue_mul, 0);
    next();
    reset = 1'b0;
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, '0, 1'b0);
    #2;
    check("post_rst_cdb_sel", cdb_sel, 0);
    check("post_rst_cdb_tag", cdb_expect_tag, 0);
    check("post_rst_busy", cdb_slots_busy, 0);
    check("post_rst_int_wins", issue_int, 1);
    check("post_rst_ld_st_loses", issue_ld_st, 0);
    next();
    idle();
    #2;
    check("post_rst_cdb_sel_int", cdb_sel, 1);
    check("post_rst_cdb_tag_int", cdb_expect_tag, 1);
    repeat (3) next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Sits between the three execution issue queues (integer, LD/ST, multiply) and the execution units.
- Each cycle it grants at most one instruction from the integer or LD/ST queue, and optionally one from the multiply queue.
- It keeps a Common Data Bus (CDB) reservation shift register, so no two results are ever scheduled onto the CDB in the same cycle.
- It tells the CDB mux which unit owns the bus each cycle and which tag that unit is expected to drive.

Parameters:
- MUL_LAT, 4, multiplier issue-to-CDB latency in cycles; legal range 2..8.
- TAG_W, 5, ROB tag width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- issueque_int_ready  in  1  integer queue holds a ready instruction
- issueque_int_tag  in  TAG_W  rd tag of that instruction
- issueque_ld_st_ready  in  1  LD/ST queue holds a ready instruction
- issueque_ld_st_tag  in  TAG_W  rd tag of that instruction
- issueque_mul_ready  in  1  multiply queue holds a ready instruction
- issueque_mul_tag  in  TAG_W  rd tag of that instruction
- Cdb_flush  in  1  branch mispredict flush; suppresses all grants in this cycle
- issue_int  out  1  grant to the integer queue (combinational)
- issue_ld_st  out  1  grant to the LD/ST queue (combinational)
- issue_mul  out  1  grant to the multiply queue (combinational)
- cdb_sel  out  2  CDB owner this cycle: 00 none, 01 int, 10 LD/ST, 11 mul (registered)
- cdb_expect_tag  out  TAG_W  tag the owning unit drives this cycle (registered)
- cdb_slots_busy  out  4  count of occupied reservation slots 0..MUL_LAT-1

Behaviour:
- State:
  - slot[k], k = 0..MUL_LAT-1, each a {src[1:0], tag[TAG_W-1:0]}; slot[k] is the CDB owner k cycles from now.
  - lru bit: 0 means integer was granted most recently.
- Reset (synchronous):
  - every slot.src = 00 and slot.tag = 0; lru = 1, so integer wins the first contention.
  - cdb_sel = 00, cdb_expect_tag = 0, cdb_slots_busy = 0.
  - All grants are 0 while reset is asserted.
- Outputs: cdb_sel = slot[0].src and cdb_expect_tag = slot[0].tag.
- Grant logic (combinational, same cycle as the ready inputs):
  - issue_mul = issueque_mul_ready & !Cdb_flush. The slot at distance MUL_LAT is always free, so mul is never blocked by int/LD-ST.
  - slot1_free = (slot[1].src == 00).
  - If only one of int / LD-ST is ready and slot1_free & !Cdb_flush: grant that one.
  - If both are ready: grant integer when lru = 1, LD/ST when lru = 0. Never grant both.
  - If slot[1] is occupied (by a mul issued MUL_LAT-1 cycles ago): neither int nor LD/ST is granted.
- Update at each posedge, when not in reset:
  - slot[k] <= slot[k+1] for k = 1..MUL_LAT-2.
  - slot[0] <= int/LD-ST grant ? {01 or 10, the granted queue's tag} : slot[1].
    - A grant and a non-empty slot[1] are mutually exclusive by construction.
  - slot[MUL_LAT-1] <= issue_mul ? {11, issueque_mul_tag} : 00.
  - lru <= 0 on an integer grant, 1 on an LD/ST grant, otherwise unchanged.
- Latency: an int/LD-ST grant in cycle t puts cdb_sel in cycle t+1; a mul grant in cycle t puts cdb_sel in cycle t+MUL_LAT.
- Cdb_flush:
  - Only blocks new grants in that cycle.
  - In-flight slots keep shifting and are still reported; the ROB discards squashed tags.
- Width rule: cdb_slots_busy is a zero-extended popcount of (slot.src != 00) over all slots.
- Assertions for the bench:
  - At most one of issue_int / issue_ld_st is high.
  - A grant is never asserted without the matching ready.

Decomposition:
- Shared package (dispatch_pkg) holds:
  - CDB_SRC_NONE / INT / LDST / MUL codes, 2 bits;
  - the cdb_slot_t struct {src, tag};
  - TAG_W default.
- One sub-module is natural: cdb_slot_shreg, the MUL_LAT-deep reservation shift register with load ports at slot 0 and slot MUL_LAT-1 and the busy popcount.
- The arbiter and lru logic stay in the top level.

Test Plan:
- Reset, then int_ready = 1 with tag 3 at cycle 1 → issue_int = 1 at cycle 1; cdb_sel = 01 and cdb_expect_tag = 3 at cycle 2; cdb_sel = 00 at cycle 3.
- int and LD/ST both ready every cycle for 4 cycles (tags 1 / 2) → grants alternate int, LD/ST, int, LD/ST; cdb_sel shows 01, 10, 01, 10 from cycle 2.
- mul_ready with tag 7 at cycle 0, MUL_LAT = 4, int ready continuously with tag 4:
  - cdb_sel = 11 with tag 7 at cycle 4;
  - issue_int = 0 at cycle 3 and cdb_sel at cycle 4 is not 01;
  - int is granted again at cycle 4.
- mul_ready in 4 consecutive cycles (tags 8..11) → issue_mul = 1 each cycle; cdb_sel = 11 at cycles 4..7 with tags 8..11; cdb_slots_busy reaches 4.
- Cdb_flush at cycle 2 with all queues ready → no grants at cycle 2; slots loaded earlier still appear on cdb_sel.
- reset asserted mid-stream with 3 slots busy → next cycle cdb_sel = 00, cdb_slots_busy = 0, lru = 1; integer wins the first contention after reset.
